// File: rtl/test_monitor.sv
// test_monitor: watches a running test program through register taps and produces a verdict.
// After en_i starts a run it drives staggered external-trap pulses and waits for the program
// to report completion (done_reg_i == 1), to raise the software end flag, or to hit the
// cycle limit. The verdict flags are sticky until reset.
//
// Ports:
//   clk, rst_n            clock (rising edge) and asynchronous active-low reset
//   en_i                  start request, sampled in IDLE only
//   done_reg_i            done register tap; exactly 1 means "test finished"
//   pass_reg_i            pass register tap; exactly 1 means "passed"
//   testnum_i             test-number tap, captured on a fail verdict
//   mends_i               software end flag, honoured after MENDS_MASK run cycles
//   ex_trap_o             one trap stimulus pulse per channel
//   state_o               IDLE=0, RUN=1, SETTLE=2, DONE=3
//   pass_o/fail_o/timeout_o/mends_end_o  sticky verdict flags
//   fail_num_o            testnum_i latched at the fail verdict
//   finish_o              one-cycle pulse on entry to DONE
module test_monitor #(
  parameter int unsigned TRAP_CH     = 2,
  parameter int unsigned TRAP_DLY    = 900,
  parameter int unsigned TRAP_LEN    = 7,
  parameter int unsigned TRAP_STRIDE = 16,
  parameter int unsigned SETTLE      = 10,
  parameter int unsigned MENDS_MASK  = 30,
  parameter int unsigned TIMEOUT     = 30000
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic               en_i,
  input  logic [31:0]        done_reg_i,
  input  logic [31:0]        pass_reg_i,
  input  logic [31:0]        testnum_i,
  input  logic               mends_i,
  output logic [TRAP_CH-1:0] ex_trap_o,
  output logic [1:0]         state_o,
  output logic               pass_o,
  output logic               fail_o,
  output logic               timeout_o,
  output logic               mends_end_o,
  output logic [31:0]        fail_num_o,
  output logic               finish_o
);

  localparam int unsigned     CntW    = $clog2(TIMEOUT + 1);
  localparam int unsigned     SetW    = (SETTLE > 1) ? $clog2(SETTLE) : 1;
  localparam logic [CntW-1:0] CntMax  = CntW'(TIMEOUT);
  localparam logic [SetW-1:0] SetLoad = SetW'(SETTLE - 1);

  typedef enum logic [1:0] {
    StIdle   = 2'd0,
    StRun    = 2'd1,
    StSettle = 2'd2,
    StDone   = 2'd3
  } state_e;

  state_e              state_q, state_d;
  logic [CntW-1:0]     cnt_q, cnt_d;
  logic [SetW-1:0]     settle_q, settle_d;
  logic [TRAP_CH-1:0]  ex_trap_q, ex_trap_d;
  logic                pass_q, pass_d;
  logic                fail_q, fail_d;
  logic                timeout_q, timeout_d;
  logic                mends_end_q, mends_end_d;
  logic [31:0]         fail_num_q, fail_num_d;
  logic                finish_q, finish_d;

  logic [CntW-1:0]     cnt_inc;
  logic                timeout_hit;
  logic                mends_ok;
  logic [TRAP_CH-1:0]  trap_win;

  assign cnt_inc     = (cnt_q == CntMax) ? cnt_q : cnt_q + CntW'(1);
  assign timeout_hit = 32'(cnt_q) >= (TIMEOUT - 1);
  assign mends_ok    = 32'(cnt_q) >= MENDS_MASK;

  // Trap windows are evaluated on the next count so the registered pulse lines up with cnt_q.
  for (genvar g = 0; g < TRAP_CH; g++) begin : g_trap
    localparam int unsigned Lo = TRAP_DLY + g * TRAP_STRIDE;
    assign trap_win[g] = (32'(cnt_d) >= Lo) && (32'(cnt_d) < Lo + TRAP_LEN);
  end

  always_comb begin
    state_d     = state_q;
    cnt_d       = cnt_q;
    settle_d    = settle_q;
    pass_d      = pass_q;
    fail_d      = fail_q;
    timeout_d   = timeout_q;
    mends_end_d = mends_end_q;
    fail_num_d  = fail_num_q;

    unique case (state_q)
      StIdle: begin
        if (en_i) begin
          state_d = StRun;
          cnt_d   = '0;
        end
      end
      StRun: begin
        cnt_d = cnt_inc;
        // Priority: done report, then software end flag, then cycle limit.
        if (done_reg_i == 32'd1) begin
          state_d  = StSettle;
          settle_d = SetLoad;
        end else if (mends_i && mends_ok) begin
          mends_end_d = 1'b1;
          state_d     = StDone;
        end else if (timeout_hit) begin
          timeout_d = 1'b1;
          state_d   = StDone;
        end
      end
      StSettle: begin
        cnt_d = cnt_inc;
        if (settle_q == '0) begin
          if (pass_reg_i == 32'd1) begin
            pass_d = 1'b1;
          end else begin
            fail_d     = 1'b1;
            fail_num_d = testnum_i;
          end
          state_d = StDone;
        end else begin
          settle_d = settle_q - SetW'(1);
          if (timeout_hit) begin
            timeout_d = 1'b1;
            state_d   = StDone;
          end
        end
      end
      StDone: begin
      end
      default: state_d = StIdle;
    endcase
  end

  always_comb begin
    ex_trap_d = '0;
    if (state_d == StRun) begin
      ex_trap_d = trap_win;
    end
  end

  assign finish_d = (state_d == StDone) && (state_q != StDone);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= StIdle;
      cnt_q       <= '0;
      settle_q    <= '0;
      ex_trap_q   <= '0;
      pass_q      <= 1'b0;
      fail_q      <= 1'b0;
      timeout_q   <= 1'b0;
      mends_end_q <= 1'b0;
      fail_num_q  <= '0;
      finish_q    <= 1'b0;
    end else begin
      state_q     <= state_d;
      cnt_q       <= cnt_d;
      settle_q    <= settle_d;
      ex_trap_q   <= ex_trap_d;
      pass_q      <= pass_d;
      fail_q      <= fail_d;
      timeout_q   <= timeout_d;
      mends_end_q <= mends_end_d;
      fail_num_q  <= fail_num_d;
      finish_q    <= finish_d;
    end
  end

  assign ex_trap_o   = ex_trap_q;
  assign state_o     = state_q;
  assign pass_o      = pass_q;
  assign fail_o      = fail_q;
  assign timeout_o   = timeout_q;
  assign mends_end_o = mends_end_q;
  assign fail_num_o  = fail_num_q;
  assign finish_o    = finish_q;

endmodule

// File: tb/tb_test_monitor.sv
// Testbench for test_monitor with small parameters so every scenario finishes in ~110 cycles.
module tb_test_monitor;

  logic        clk        = 1'b0;
  logic        rst_n      = 1'b0;
  logic        en_i       = 1'b0;
  logic        mends_i    = 1'b0;
  logic [31:0] done_reg_i = '0;
  logic [31:0] pass_reg_i = '0;
  logic [31:0] testnum_i  = '0;
  logic [1:0]  ex_trap_o;
  logic [1:0]  state_o;
  logic        pass_o;
  logic        fail_o;
  logic        timeout_o;
  logic        mends_end_o;
  logic [31:0] fail_num_o;
  logic        finish_o;

  int total = 0;
  int bad   = 0;

  always #5 clk = ~clk;

  test_monitor #(
    .TRAP_CH    (2),
    .TRAP_DLY   (20),
    .TRAP_LEN   (7),
    .TRAP_STRIDE(10),
    .SETTLE     (10),
    .MENDS_MASK (30),
    .TIMEOUT    (100)
  ) dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .en_i       (en_i),
    .done_reg_i (done_reg_i),
    .pass_reg_i (pass_reg_i),
    .testnum_i  (testnum_i),
    .mends_i    (mends_i),
    .ex_trap_o  (ex_trap_o),
    .state_o    (state_o),
    .pass_o     (pass_o),
    .fail_o     (fail_o),
    .timeout_o  (timeout_o),
    .mends_end_o(mends_end_o),
    .fail_num_o (fail_num_o),
    .finish_o   (finish_o)
  );

  // One scenario: stimulus cycles (relative to cnt) and expected outcome.
  typedef struct {
    int          done_at;   // cycle done_reg_i is pulsed, -1 for never
    logic [31:0] done_val;
    logic [31:0] pass_val;
    logic [31:0] tnum;
    int          mends_a;   // cycles mends_i is pulsed, -1 for never
    int          mends_b;
    int          run_end;   // first cycle not in RUN
    int          done_exp;  // first cycle in DONE
    logic [3:0]  flags;     // {pass, fail, timeout, mends_end}
    logic [31:0] fail_num;
  } vec_t;

  vec_t tbl[9];

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h", nm, act, exp);
    end
  endtask

  function automatic logic [1:0] exp_state(input int c, input int run_end, input int done_exp);
    if (c < run_end) return 2'd1;
    if (c < done_exp) return 2'd2;
    return 2'd3;
  endfunction

  function automatic logic [1:0] exp_trap(input int c, input int run_end);
    logic b0, b1;
    b0 = (c < run_end) && (c >= 20) && (c < 27);
    b1 = (c < run_end) && (c >= 30) && (c < 37);
    return {b1, b0};
  endfunction

  function automatic logic [3:0] flags_now();
    return {pass_o, fail_o, timeout_o, mends_end_o};
  endfunction

  task automatic do_reset();
    @(negedge clk);
    rst_n      = 1'b0;
    en_i       = 1'b0;
    done_reg_i = '0;
    mends_i    = 1'b0;
    @(negedge clk);
    chk("rst state", 32'(state_o), 32'd0);
    chk("rst trap", 32'(ex_trap_o), 32'd0);
    chk("rst flags", 32'(flags_now()), 32'd0);
    chk("rst fail_num", fail_num_o, 32'd0);
    chk("rst finish", 32'(finish_o), 32'd0);
    @(negedge clk);
    rst_n = 1'b1;
    repeat (3) begin
      @(negedge clk);
      chk("idle hold", 32'(state_o), 32'd0);
    end
  endtask

  task automatic run_vec(input vec_t v, input int id);
    logic [3:0] ef;
    pass_reg_i = v.pass_val;
    testnum_i  = v.tnum;
    en_i       = 1'b1;
    for (int c = 0; c <= 110; c++) begin
      @(negedge clk);
      en_i = 1'b0;
      chk($sformatf("v%0d c%0d state", id, c), 32'(state_o),
          32'(exp_state(c, v.run_end, v.done_exp)));
      chk($sformatf("v%0d c%0d trap", id, c), 32'(ex_trap_o), 32'(exp_trap(c, v.run_end)));
      chk($sformatf("v%0d c%0d finish", id, c), 32'(finish_o), 32'(c == v.done_exp));
      ef = (c >= v.done_exp) ? v.flags : 4'b0000;
      chk($sformatf("v%0d c%0d flags", id, c), 32'(flags_now()), 32'(ef));
      done_reg_i = (c == v.done_at) ? v.done_val : 32'h0;
      mends_i    = (c == v.mends_a) || (c == v.mends_b);
    end
    done_reg_i = '0;
    mends_i    = 1'b0;
    chk($sformatf("v%0d fail_num", id), fail_num_o, v.fail_num);
    // DONE is terminal even with en_i asserted again.
    en_i = 1'b1;
    repeat (4) @(negedge clk);
    chk($sformatf("v%0d done hold state", id), 32'(state_o), 32'd3);
    chk($sformatf("v%0d done hold flags", id), 32'(flags_now()), 32'(v.flags));
    chk($sformatf("v%0d done hold finish", id), 32'(finish_o), 32'd0);
    en_i = 1'b0;
  endtask

  initial begin
    int n0, n1, first0;

    tbl[0] = '{-1, 32'd0, 32'd0, 32'd0,          -1, -1, 100, 100, 4'b0010, 32'd0};
    tbl[1] = '{40, 32'd1, 32'd1, 32'd5,          -1, -1,  41,  51, 4'b1000, 32'd0};
    tbl[2] = '{40, 32'd1, 32'd0, 32'h17,         -1, -1,  41,  51, 4'b0100, 32'h17};
    tbl[3] = '{-1, 32'd0, 32'd0, 32'd0,          10, 50,  51,  51, 4'b0001, 32'd0};
    tbl[4] = '{45, 32'd1, 32'd1, 32'd0,          45, 48,  46,  56, 4'b1000, 32'd0};
    tbl[5] = '{95, 32'd1, 32'd1, 32'd0,          -1, -1,  96, 100, 4'b0010, 32'd0};
    tbl[6] = '{40, 32'd2, 32'd1, 32'd0,          -1, -1, 100, 100, 4'b0010, 32'd0};
    tbl[7] = '{30, 32'd1, 32'h101, 32'hDEADBEEF, -1, -1,  31,  41, 4'b0100, 32'hDEADBEEF};
    tbl[8] = '{-1, 32'd0, 32'd0, 32'd0,          29, 30,  31,  31, 4'b0001, 32'd0};

    for (int i = 0; i < 9; i++) begin
      do_reset();
      run_vec(tbl[i], i);
    end

    // Reset in the middle of the channel 0 pulse, then a clean restart.
    do_reset();
    en_i = 1'b1;
    for (int c = 0; c <= 23; c++) begin
      @(negedge clk);
      en_i = 1'b0;
    end
    chk("midpulse trap", 32'(ex_trap_o), 32'd1);
    #2 rst_n = 1'b0;
    #1;
    chk("async rst trap", 32'(ex_trap_o), 32'd0);
    chk("async rst state", 32'(state_o), 32'd0);
    do_reset();
    n0 = 0;
    n1 = 0;
    first0 = -1;
    en_i = 1'b1;
    for (int c = 0; c <= 45; c++) begin
      @(negedge clk);
      en_i = 1'b0;
      if (ex_trap_o[0]) begin
        n0++;
        if (first0 < 0) first0 = c;
      end
      if (ex_trap_o[1]) n1++;
    end
    chk("restart ch0 len", 32'(n0), 32'd7);
    chk("restart ch0 start", 32'(first0), 32'd20);
    chk("restart ch1 len", 32'(n1), 32'd7);

    // Reset in the middle of SETTLE, then a short run through SETTLE to a pass.
    do_reset();
    pass_reg_i = 32'd1;
    en_i = 1'b1;
    for (int c = 0; c <= 45; c++) begin
      @(negedge clk);
      en_i = 1'b0;
      done_reg_i = (c == 40) ? 32'd1 : 32'd0;
    end
    chk("midsettle state", 32'(state_o), 32'd2);
    #2 rst_n = 1'b0;
    #1;
    chk("midsettle rst state", 32'(state_o), 32'd0);
    chk("midsettle rst flags", 32'(flags_now()), 32'd0);
    do_reset();
    en_i = 1'b1;
    for (int c = 0; c <= 16; c++) begin
      @(negedge clk);
      en_i = 1'b0;
      if (c == 15) chk("short settle last", 32'(state_o), 32'd2);
      if (c == 16) begin
        chk("short settle done", 32'(state_o), 32'd3);
        chk("short settle pass", 32'(flags_now()), 32'(4'b1000));
      end
      done_reg_i = (c == 5) ? 32'd1 : 32'd0;
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/test_monitor.md
TEST_MONITOR -- requirements
Module: test_monitor

Interface
REQ-001 SHALL have parameter TRAP_CH, default 2, meaning number of external-trap stimulus channels (1..8).
REQ-002 SHALL have parameter TRAP_DLY, default 900, meaning RUN cycles before channel 0 asserts.
REQ-003 SHALL have parameter TRAP_LEN, default 7, meaning width in cycles of each trap pulse (>=1).
REQ-004 SHALL have parameter TRAP_STRIDE, default 16, meaning start offset between channel k and k+1 (>=TRAP_LEN).
REQ-005 SHALL have parameter SETTLE, default 10, meaning cycles between done detection and pass sampling (>=1).
REQ-006 SHALL have parameter MENDS_MASK, default 30, meaning initial RUN cycles during which mends_i is ignored.
REQ-007 SHALL have parameter TIMEOUT, default 30000, meaning RUN+SETTLE cycle limit; counter width is $clog2(TIMEOUT+1).
REQ-008 SHALL have port clk  input  1  single clock, rising edge.
REQ-009 SHALL have port rst_n  input  1  reset, asynchronous, active-low.
REQ-010 SHALL have port en_i  input  1  start request, level.
REQ-011 SHALL have port done_reg_i  input  32  done register tap (x26).
REQ-012 SHALL have port pass_reg_i  input  32  pass register tap (x27).
REQ-013 SHALL have port testnum_i  input  32  test-number tap (x3).
REQ-014 SHALL have port mends_i  input  1  software end flag (CSR mends).
REQ-015 SHALL have port ex_trap_o  output  TRAP_CH  trap stimulus pulses, one bit per channel.
REQ-016 SHALL have port state_o  output  2  IDLE=0, RUN=1, SETTLE=2, DONE=3.
REQ-017 SHALL have ports pass_o, fail_o, timeout_o, mends_end_o  output  1 each  sticky verdict flags.
REQ-018 SHALL have port fail_num_o  output  32  testnum_i latched at fail verdict.
REQ-019 SHALL have port finish_o  output  1  one-cycle pulse on entry to DONE.

Function
REQ-020 FSM SHALL move IDLE->RUN on the first clk edge with en_i=1; cycle counter cnt cleared to 0 on that edge.
REQ-021 cnt SHALL increment by 1 every cycle in RUN and SETTLE, saturating at TIMEOUT; held in IDLE and DONE.
REQ-022 ex_trap_o[k] SHALL be registered high exactly while in RUN and TRAP_DLY+k*TRAP_STRIDE <= cnt < TRAP_DLY+k*TRAP_STRIDE+TRAP_LEN; low otherwise, including on any state exit.
REQ-023 In RUN, done_reg_i==1 SHALL move to SETTLE and load settle counter with SETTLE-1.
REQ-024 In SETTLE, settle counter SHALL decrement each cycle; at 0 the block SHALL sample pass_reg_i, set pass_o if ==1 else set fail_o and latch fail_num_o<=testnum_i, and enter DONE.
REQ-025 In RUN with cnt>=MENDS_MASK, mends_i==1 SHALL set mends_end_o and enter DONE.
REQ-026 When cnt reaches TIMEOUT-1 in RUN or SETTLE without another verdict that cycle, timeout_o SHALL set and FSM enter DONE.
REQ-027 Same-cycle priority SHALL be done_reg_i > mends_i > timeout; exactly one verdict flag is ever set per run.
REQ-028 done_reg_i values other than exactly 1 SHALL be ignored; mends_i in SETTLE SHALL be ignored.
REQ-029 DONE SHALL be terminal: flags held, en_i ignored, until rst_n asserted.
REQ-030 finish_o SHALL be high for exactly the single cycle after the transition edge into DONE.
REQ-031 en_i deassertion after start SHALL have no effect.

Reset
REQ-032 rst_n=0 SHALL asynchronously force state IDLE, cnt=0, settle counter=0, ex_trap_o=0, all flags 0, fail_num_o=0, finish_o=0, including mid-pulse or mid-SETTLE.
REQ-033 After rst_n release, the block SHALL stay IDLE until en_i is sampled high.

Verification (TRAP_CH=2, TRAP_DLY=20, TRAP_LEN=7, TRAP_STRIDE=10, SETTLE=10, MENDS_MASK=30, TIMEOUT=100)
REQ-034 en_i=1, no other stimulus -> ex_trap_o[0] high cnt 20..26, ex_trap_o[1] high cnt 30..36; timeout_o=1, finish_o pulse once, state_o=3.
REQ-035 done_reg_i=1 at cnt 40, pass_reg_i=1 -> state_o=2 for 10 cycles, then pass_o=1, fail_o=0.
REQ-036 done_reg_i=1 at cnt 40, pass_reg_i=0, testnum_i=0x17 -> fail_o=1, fail_num_o=0x17.
REQ-037 mends_i=1 at cnt 10 then at cnt 50 -> first ignored, mends_end_o=1 at 50; mends_i and done_reg_i=1 same cycle -> SETTLE, mends ignored.
REQ-038 rst_n=0 at cnt 23 (channel 0 mid-pulse) -> ex_trap_o=0 immediately, state_o=0; restart gives full 7-cycle pulses.
REQ-039 done_reg_i=1 at cnt 95 -> timeout at cnt 99 during SETTLE; timeout_o=1, pass_o=fail_o=0.
